// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB bus among N_MASTERS core-side masters.
// Optional ACCESS timeout abort is built when VMICRO16_APB_ARB_TIMEOUT_EN is defined.
module vmicro16_apb_rr_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 16'hDEAD,
  localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] M_PADDR,
  input  logic [N_MASTERS-1:0]            M_PWRITE,
  input  logic [N_MASTERS-1:0]            M_PSELx,
  input  logic [N_MASTERS-1:0]            M_PENABLE,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] M_PWDATA,
  output logic [N_MASTERS*DATA_WIDTH-1:0] M_PRDATA,
  output logic [N_MASTERS-1:0]            M_PREADY,
  output logic [ADDR_WIDTH-1:0]           A_PADDR,
  output logic                            A_PWRITE,
  output logic                            A_PSELx,
  output logic                            A_PENABLE,
  output logic [DATA_WIDTH-1:0]           A_PWDATA,
  input  logic [DATA_WIDTH-1:0]           A_PRDATA,
  input  logic                            A_PREADY,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_q, rr_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [ID_W-1:0]         winner;
  logic                    found;
  logic                    timeout_hit;

  // First requester at or after the rotating pointer, wrapping past the last master.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && M_PSELx[(int'(rr_q) + k) % N_MASTERS]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_q) + k) % N_MASTERS);
      end
    end
  end

`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ACCESS && !A_PREADY) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q == ACCESS) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_id_d = grant_id_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    M_PREADY   = '0;
    M_PRDATA   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = winner;
          paddr_d    = M_PADDR[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d   = M_PWRITE[winner];
          pwdata_d   = M_PWDATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          state_d    = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (A_PREADY || timeout_hit) begin
          // A real slave response beats a coincident timeout; nothing is returned under reset.
          if (!reset) begin
            M_PREADY[grant_id_q] = 1'b1;
            M_PRDATA[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH] = A_PREADY ? A_PRDATA : TIMEOUT_DATA;
          end
          rr_d     = (int'(grant_id_q) == N_MASTERS - 1) ? '0 : grant_id_q + 1'b1;
          paddr_d  = '0;
          pwrite_d = 1'b0;
          pwdata_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_id_q <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_id_q <= grant_id_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
    end
  end

  // A master may only raise PENABLE while it is selecting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((M_PENABLE & ~M_PSELx) == '0);
    end
  end

  assign A_PADDR   = paddr_q;
  assign A_PWRITE  = pwrite_q;
  assign A_PWDATA  = pwdata_q;
  assign A_PSELx   = (state_q != IDLE);
  assign A_PENABLE = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Self-checking bench for vmicro16_apb_rr_arbiter: scoreboard of expected completions per master
// plus scenario tasks; the timeout scenario is built when VMICRO16_APB_ARB_TIMEOUT_EN is defined.
module tb_vmicro16_apb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N*AW-1:0] m_paddr = '0;
  logic [N-1:0]    m_pwrite = '0, m_psel = '0, m_penable = '0;
  logic [N*DW-1:0] m_pwdata = '0;
  logic [N*DW-1:0] m_prdata;
  logic [N-1:0]    m_pready;
  logic [AW-1:0]   a_paddr;
  logic            a_pwrite, a_psel, a_penable;
  logic [DW-1:0]   a_pwdata;
  logic [DW-1:0]   a_prdata = '0;
  logic            a_pready = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   done_cycle[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   cycle = 0;
  int   pready_cnt[N];
  int   stream_left[N];
  int   stream_seq[N];
  int   slave_wait = 0;
  int   slave_cnt = 0;

  vmicro16_apb_rr_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .reset(reset),
    .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel), .M_PENABLE(m_penable),
    .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready),
    .A_PADDR(a_paddr), .A_PWRITE(a_pwrite), .A_PSELx(a_psel), .A_PENABLE(a_penable),
    .A_PWDATA(a_pwdata), .A_PRDATA(a_prdata), .A_PREADY(a_pready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h1224;
  endfunction

  function automatic logic [AW-1:0] stream_addr(input int id, input int seq);
    return AW'(32'h100 + id * 16 + seq);
  endfunction

  task automatic load_master(input int id, input logic [AW-1:0] addr, input logic wr,
                             input logic [DW-1:0] wd, input logic [DW-1:0] exp_data);
    exp_t e;
    m_paddr[id*AW +: AW]  = addr;
    m_pwrite[id]          = wr;
    m_pwdata[id*DW +: DW] = wd;
    m_psel[id]            = 1'b1;
    e.id   = id;
    e.data = exp_data;
    sb.push_back(e);
  endtask

  // Downstream slave: inserts slave_wait wait states, then returns data derived from the address.
  initial forever begin
    @(negedge clk);
    if (a_psel && a_penable) begin
      if (slave_cnt >= slave_wait) begin
        a_pready = 1'b1;
        a_prdata = slave_data(a_paddr);
      end else begin
        a_pready = 1'b0;
        a_prdata = '0;
        slave_cnt++;
      end
    end else begin
      a_pready  = 1'b0;
      a_prdata  = '0;
      slave_cnt = 0;
    end
  end

  // Completion monitor: scoreboard compare, then release or reload the completed master.
  initial forever begin
    logic [N-1:0] loaded;
    @(negedge clk);
    #1;
    loaded = '0;
    if (m_pready != '0) begin
      checks++;
      if (!$onehot(m_pready)) begin
        errors++;
        $display("[TB] FAIL pready_onehot: got %b, expected one-hot", m_pready);
      end else begin
        int i;
        int idx;
        logic [N*DW-1:0] mask;
        i = 0;
        for (int k = 0; k < N; k++) if (m_pready[k]) i = k;
        pready_cnt[i]++;
        done_count++;
        grant_log.push_back(i);
        done_cycle.push_back(cycle);
        idx = -1;
        for (int j = 0; j < sb.size(); j++) if (idx < 0 && sb[j].id == i) idx = j;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pready: got pready for master %0d, expected none", i);
        end else begin
          if (m_prdata[i*DW +: DW] !== sb[idx].data) begin
            errors++;
            $display("[TB] FAIL prdata_m%0d: got %h, expected %h", i, m_prdata[i*DW +: DW], sb[idx].data);
          end
          sb.delete(idx);
        end
        mask = '0;
        mask[i*DW +: DW] = '1;
        checks++;
        if ((m_prdata & ~mask) !== '0) begin
          errors++;
          $display("[TB] FAIL prdata_other_slices: got %h, expected 0 outside master %0d", m_prdata, i);
        end
        if (stream_left[i] > 0) begin
          stream_left[i]--;
          stream_seq[i]++;
          load_master(i, stream_addr(i, stream_seq[i]), 1'b0, '0, slave_data(stream_addr(i, stream_seq[i])));
          loaded[i] = 1'b1;
        end else begin
          m_psel[i] = 1'b0;
        end
      end
    end
    m_penable = m_psel & ~loaded;
  end

  task automatic wait_done(input int target, input int budget, input string name);
    for (int k = 0; k < budget && done_count < target; k++) begin
      @(negedge clk);
      #2;
    end
    checks++;
    if (done_count < target) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d completions, expected %0d", name, done_count, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    m_psel    = '0;
    m_penable = '0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      stream_left[i] = 0;
      stream_seq[i]  = 0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({a_psel, a_penable, a_pwrite, busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {a_psel, a_penable, a_pwrite, busy});
    end
    checks++;
    if (grant_id !== 2'd0 || a_paddr !== '0 || a_pwdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got gid=%0d addr=%h wdata=%h, expected 0", grant_id, a_paddr, a_pwdata);
    end
    checks++;
    if (m_pready !== '0 || m_prdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mouts: got %b/%h, expected 0", m_pready, m_prdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int base;
    base = done_count;
    @(negedge clk);
    load_master(0, 20'h00010, 1'b0, '0, 16'h1234);
    @(negedge clk);
    #2;
    checks++;
    if ({a_psel, a_penable, busy} !== 3'b101 || a_paddr !== 20'h00010 || grant_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_setup: got sel/en/busy=%b addr=%h gid=%0d, expected 101 00010 0",
               {a_psel, a_penable, busy}, a_paddr, grant_id);
    end
    @(negedge clk);
    #2;
    checks++;
    if (a_penable !== 1'b1 || m_pready !== 4'b0001 || m_prdata[15:0] !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL single_access: got en=%b pready=%b data=%h, expected 1 0001 1234",
               a_penable, m_pready, m_prdata[15:0]);
    end
    @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || a_psel !== 1'b0 || a_paddr !== '0 || done_count !== base + 1) begin
      errors++;
      $display("[TB] FAIL single_idle: got busy=%b sel=%b addr=%h done=%0d, expected 0 0 0 %0d",
               busy, a_psel, a_paddr, done_count, base + 1);
    end
  endtask

  task automatic test_two_requesters();
    int start;
    do_reset();
    start = grant_log.size();
    @(negedge clk);
    load_master(0, 20'h00030, 1'b0, '0, slave_data(20'h00030));
    load_master(2, 20'h00040, 1'b0, '0, slave_data(20'h00040));
    wait_done(done_count + 2, 20, "two_req");
    if (grant_log.size() >= start + 2) begin
      checks++;
      if (grant_log[start] != 0 || grant_log[start+1] != 2) begin
        errors++;
        $display("[TB] FAIL two_req_order: got %0d,%0d, expected 0,2", grant_log[start], grant_log[start+1]);
      end
      checks++;
      if (done_cycle[start+1] - done_cycle[start] != 3) begin
        errors++;
        $display("[TB] FAIL two_req_cadence: got %0d cycles, expected 3", done_cycle[start+1] - done_cycle[start]);
      end
    end
  endtask

  task automatic test_round_robin();
    int start;
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    start = grant_log.size();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      stream_left[i] = 1;
      load_master(i, stream_addr(i, 0), 1'b0, '0, slave_data(stream_addr(i, 0)));
    end
    wait_done(done_count + 8, 60, "rr");
    if (grant_log.size() >= start + 8) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (grant_log[start+k] != exp_seq[k]) begin
          errors++;
          $display("[TB] FAIL rr_grant_%0d: got %0d, expected %0d", k, grant_log[start+k], exp_seq[k]);
        end
      end
      for (int k = 1; k < 8; k++) begin
        checks++;
        if (done_cycle[start+k] - done_cycle[start+k-1] != 3) begin
          errors++;
          $display("[TB] FAIL rr_cadence_%0d: got %0d cycles, expected 3", k,
                   done_cycle[start+k] - done_cycle[start+k-1]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int base;
    int acc;
    base = done_count;
    acc = 0;
    slave_wait = 3;
    @(negedge clk);
    load_master(1, 20'h00020, 1'b1, 16'hBEEF, slave_data(20'h00020));
    for (int k = 0; k < 20 && done_count == base; k++) begin
      @(negedge clk);
      #2;
      if (a_penable) begin
        acc++;
        checks++;
        if (a_pwdata !== 16'hBEEF || a_pwrite !== 1'b1 || a_paddr !== 20'h00020) begin
          errors++;
          $display("[TB] FAIL ws_hold: got wdata=%h wr=%b addr=%h, expected BEEF 1 00020", a_pwdata, a_pwrite, a_paddr);
        end
      end
    end
    checks++;
    if (acc != 4) begin
      errors++;
      $display("[TB] FAIL ws_access_cycles: got %0d, expected 4", acc);
    end
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (done_count != base + 1) begin
      errors++;
      $display("[TB] FAIL ws_pulses: got %0d, expected 1", done_count - base);
    end
    slave_wait = 0;
  endtask

  task automatic test_reset_mid();
    int p2;
    int start;
    p2 = pready_cnt[2];
    slave_wait = 5;
    @(negedge clk);
    load_master(2, 20'h00050, 1'b0, '0, slave_data(20'h00050));
    for (int k = 0; k < 10 && !a_penable; k++) begin
      @(negedge clk);
      #2;
    end
    checks++;
    if (a_penable !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL rstmid_access: got en=%b gid=%0d, expected 1 2", a_penable, grant_id);
    end
    reset = 1'b1;
    m_psel[2] = 1'b0;
    m_penable[2] = 1'b0;
    sb.delete();
    @(negedge clk);
    #2;
    checks++;
    if ({a_psel, a_penable, busy} !== 3'b000 || grant_id !== 2'd0 || m_pready !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_abort: got sel/en/busy=%b gid=%0d pready=%b, expected 000 0 0000",
               {a_psel, a_penable, busy}, grant_id, m_pready);
    end
    reset = 1'b0;
    slave_wait = 0;
    @(negedge clk);
    load_master(3, 20'h00060, 1'b0, '0, slave_data(20'h00060));
    start = grant_log.size();
    wait_done(done_count + 1, 20, "rstmid_after");
    checks++;
    if (grant_log.size() != start + 1 || grant_log[grant_log.size()-1] != 3 || pready_cnt[2] != p2) begin
      errors++;
      $display("[TB] FAIL rstmid_followup: got log=%0d m2cnt=%0d, expected one grant to 3 and m2cnt=%0d",
               grant_log.size() - start, pready_cnt[2], p2);
    end
  endtask

`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    int start;
    int acc;
    base = done_count;
    start = grant_log.size();
    acc = 0;
    slave_wait = 1000;
    @(negedge clk);
    load_master(0, 20'h00070, 1'b0, '0, 16'hDEAD);
    load_master(1, 20'h00080, 1'b0, '0, 16'hDEAD);
    for (int k = 0; k < 20 && done_count == base; k++) begin
      @(negedge clk);
      #2;
      if (a_penable) acc++;
    end
    checks++;
    if (acc != 4) begin
      errors++;
      $display("[TB] FAIL tmo_access_cycles: got %0d, expected 4", acc);
    end
    @(negedge clk);
    #2;
    checks++;
    if (a_psel !== 1'b0 || a_penable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_release: got sel=%b en=%b, expected 0 0", a_psel, a_penable);
    end
    wait_done(base + 2, 30, "tmo");
    checks++;
    if (grant_log.size() < start + 2 || grant_log[start] != 0 || grant_log[start+1] != 1) begin
      errors++;
      $display("[TB] FAIL tmo_order: got %0d grants, expected 0 then 1", grant_log.size() - start);
    end
    slave_wait = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      pready_cnt[i]  = 0;
      stream_left[i] = 0;
      stream_seq[i]  = 0;
    end
    test_reset();
    test_single_read();
    test_two_requesters();
    test_round_robin();
    test_wait_states();
    test_reset_mid();
`ifdef VMICRO16_APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
